// File: rtl/risc_pc_stack_pkg.sv
// Shared sizing defaults and operation encodings for the RISC return-address stack.
`default_nettype none

package risc_pc_stack_pkg;

  localparam int STACK_DEPTH = 8;
  localparam int PC_WIDTH    = 8;
  localparam int STACK_PTR_W = 4;

  // Encoding matches the {PushEnbl, PopEnbl} strobe pair from control.
  typedef enum logic [1:0] {
    STK_IDLE = 2'b00,
    STK_POP  = 2'b01,
    STK_PUSH = 2'b10,
    STK_XCHG = 2'b11
  } stk_op_e;

  function automatic stk_op_e decode_op(input logic push, input logic pop);
    return stk_op_e'({push, pop});
  endfunction

endpackage

`default_nettype wire

// File: rtl/risc_stack_mem.sv
// Return-address storage: DEPTH x AW registers, one synchronous write port, one async read port.
`default_nettype none

module risc_stack_mem
  import risc_pc_stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int AW    = PC_WIDTH,
  parameter int IW    = $clog2(STACK_DEPTH)
) (
  input  logic          Clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [AW-1:0] wr_data,
  input  logic [IW-1:0] rd_addr,
  output logic [AW-1:0] rd_data
);

  // Contents are deliberately not reset; validity is tracked by the stack pointer.
  logic [AW-1:0] mem_q [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

`default_nettype wire

// File: rtl/risc_pc_stack.sv
// Return-address stack with registered pop data, status and sticky errors.
// Define RISC_STACK_WRAP_EN to make the stack circular (push while full overwrites the oldest entry).
`default_nettype none

module risc_pc_stack
  import risc_pc_stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int AW    = PC_WIDTH,
  parameter int PW    = STACK_PTR_W
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          PushEnbl,
  input  logic          PopEnbl,
  input  logic [AW-1:0] Push_Data,
  input  logic          Clr_Err,
  output logic [AW-1:0] Pop_Data,
  output logic          Pop_Valid,
  output logic          Stack_Empty,
  output logic          Stack_Full,
  output logic [PW-1:0] Stack_Count,
  output logic          Overflow,
  output logic          Underflow
);

  localparam int IW = $clog2(DEPTH);

  logic [PW-1:0] count_q, count_d;
  logic [IW-1:0] head_q, head_d;
  logic [AW-1:0] pop_data_q, pop_data_d;
  logic          pop_valid_q, pop_valid_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [IW-1:0] top_idx;
  logic [AW-1:0] top_data;
  stk_op_e       op;

  assign op      = decode_op(PushEnbl, PopEnbl);
  // head_q is the next free slot, so the top entry lives one below it (mod DEPTH).
  assign top_idx = head_q - IW'(1);

  risc_stack_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .IW    (IW)
  ) u_mem (
    .Clk     (Clk),
    .wr_en   (mem_we & ~Reset),
    .wr_addr (mem_waddr),
    .wr_data (Push_Data),
    .rd_addr (top_idx),
    .rd_data (top_data)
  );

  always_comb begin
    count_d     = count_q;
    head_d      = head_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    ovf_d       = ovf_q & ~Clr_Err;
    unf_d       = unf_q & ~Clr_Err;
    mem_we      = 1'b0;
    mem_waddr   = head_q;

    case (op)
      STK_PUSH: begin
        if (!full_q) begin
          mem_we  = 1'b1;
          head_d  = head_q + IW'(1);
          count_d = count_q + PW'(1);
        end else begin
`ifdef RISC_STACK_WRAP_EN
          mem_we = 1'b1;
          head_d = head_q + IW'(1);
`else
          ovf_d  = 1'b1;
`endif
        end
      end
      STK_POP: begin
        pop_valid_d = 1'b1;
        if (!empty_q) begin
          pop_data_d = top_data;
          head_d     = top_idx;
          count_d    = count_q - PW'(1);
        end else begin
          pop_data_d = '0;
          unf_d      = 1'b1;
        end
      end
      STK_XCHG: begin
        pop_valid_d = 1'b1;
        mem_we      = 1'b1;
        if (!empty_q) begin
          // Pop then push into the same slot: old top is read before the write lands.
          pop_data_d = top_data;
          mem_waddr  = top_idx;
        end else begin
          pop_data_d = '0;
          unf_d      = 1'b1;
          head_d     = head_q + IW'(1);
          count_d    = count_q + PW'(1);
        end
      end
      default: ;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == PW'(DEPTH));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q     <= '0;
      head_q      <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign Pop_Data    = pop_data_q;
  assign Pop_Valid   = pop_valid_q;
  assign Stack_Empty = empty_q;
  assign Stack_Full  = full_q;
  assign Stack_Count = count_q;
  assign Overflow    = ovf_q;
  assign Underflow   = unf_q;

endmodule

`default_nettype wire

// File: doc/risc_pc_stack.md
Name: risc_pc_stack

Overview:
- Return-address stack for the RISC core.
- It is the responder to the control unit's PushEnbl/PopEnbl strobes, which are asserted in the EXECUTE state for conditional calls and returns.
- On a push it stores the supplied return PC. On a pop it returns the top entry one cycle later, which is the WRITEBACK cycle, so the PC logic can load it.
- Reports full/empty status and sticky overflow/underflow errors.

Parameters:
- DEPTH, 8, number of stack entries; power of two, 2 to 64.
- AW, 8, width of a PC / return address in bits.
- PW, 4, width of the pointer/count; must satisfy 2**(PW-1) >= DEPTH.

Ports:
- Clk  in  1  CPU clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- PushEnbl  in  1  push request; single-cycle strobe from control.
- PopEnbl  in  1  pop request; single-cycle strobe from control.
- Push_Data  in  AW  return address to store; sampled when PushEnbl=1.
- Clr_Err  in  1  synchronous clear of the sticky error flags.
- Pop_Data  out  AW  popped address; registered; held until the next pop.
- Pop_Valid  out  1  one-cycle pulse the cycle after an accepted pop.
- Stack_Empty  out  1  count==0; registered.
- Stack_Full  out  1  count==DEPTH; registered.
- Stack_Count  out  PW  number of valid entries.
- Overflow  out  1  sticky; set by a push while full.
- Underflow  out  1  sticky; set by a pop while empty.

Behaviour:
- Reset: Pop_Data=0, Pop_Valid=0, Stack_Empty=1, Stack_Full=0, Stack_Count=0, Overflow=0, Underflow=0, pointer=0. Storage contents are not cleared.
- Reset mid-operation: Reset wins over any concurrent push or pop; the stack is logically emptied.
- Storage: entries mem[0..DEPTH-1]; pointer sp = Stack_Count; top of stack is mem[sp-1].
- Operation is selected per cycle by {PushEnbl, PopEnbl}:
  - 00: idle; Pop_Valid=0; all other state held.
  - 10, not full: mem[sp] <= Push_Data; sp <= sp+1.
  - 10, full: Push_Data is discarded; sp is unchanged; Overflow <= 1.
  - 01, not empty: Pop_Data <= mem[sp-1]; sp <= sp-1; Pop_Valid <= 1 in the next cycle.
  - 01, empty: Pop_Data <= 0; Pop_Valid <= 1; sp is unchanged; Underflow <= 1.
  - 11, not empty: pop first, then push into the same slot. Pop_Data <= the old top; mem[sp-1] <= Push_Data; sp is unchanged; Pop_Valid <= 1.
  - 11, empty: Pop_Data <= 0; Underflow <= 1; the push is performed (mem[0] <= Push_Data, sp <= 1); Pop_Valid <= 1.
- Latency:
  - A pop's result appears on Pop_Data one cycle after the strobe.
  - Status outputs reflect the new count one cycle after the strobe.
- Back-to-back strobes on consecutive cycles must all be honoured; there is no busy state.
- Errors:
  - Overflow and Underflow stay set until Reset or Clr_Err.
  - If Clr_Err coincides with a new error event, the set wins.
- Width: pointer arithmetic is modulo 2**PW. Saturation is enforced only by the full/empty checks, so sp never exceeds DEPTH.

Optional Feature:
- Macro: RISC_STACK_WRAP_EN.
- Defined: the stack is circular.
  - A push while full overwrites the oldest entry. The head pointer advances modulo DEPTH, the count stays at DEPTH, and Overflow is never set.
  - Pops return the entries in LIFO order over the retained DEPTH entries.
- Undefined: saturating behaviour exactly as described above.

Decomposition:
- risc.h gains these defines: `STACK_DEPTH (8), `PC_WIDTH (8), `STACK_PTR_W (4), plus the operation encodings `STK_IDLE, `STK_PUSH, `STK_POP, `STK_XCHG.
- One sub-module: risc_stack_mem.
  - DEPTH x AW register array.
  - One synchronous write port and one asynchronous read port addressed by sp-1.
  - The pointer, flag and pop logic stay in risc_pc_stack.

Test Plan:
1. Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times -> Pop_Data = 0x33, 0x22, 0x11, each with a Pop_Valid pulse one cycle after its strobe; Stack_Empty=1 at the end.
2. Push 9 times with DEPTH=8 -> Stack_Full=1 after the 8th; Overflow=1 after the 9th; 8 pops return the 8th..1st values; the 9th value is absent.
3. Pop on an empty stack -> Pop_Data=0x00, Pop_Valid=1, Underflow=1, Stack_Count stays 0. Then Clr_Err -> Underflow=0.
4. With 0xA0 on top, count 2, assert push 0xB5 and pop together -> Pop_Data=0xA0, Stack_Count=2; the next pop returns 0xB5.
5. Count 3, assert Reset together with PushEnbl -> count=0, Stack_Empty=1, Pop_Valid=0; the next pop sets Underflow.
6. With RISC_STACK_WRAP_EN, DEPTH=8: push 1..10 then pop 8 -> returns 10 down to 3; Overflow stays 0.
